fir_decim_out: RTL and testbench

- Output stage directly downstream of the 16-bit FIR filter.
- Takes one filtered sample per qualified clock, keeps every DECIM-th sample, and scales it by an arithmetic right shift with saturation to OUT_W bits.
- Buffers kept samples in a small FIFO and presents them to the consumer over a valid/ready handshake.
- Reports sticky saturation and overflow flags.

---
 rtl/fir_decim_out.sv | 184 ++++++++++++++++++
 tb/tb_fir_decim_out.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_out.sv
// fir_decim_out: keeps every DECIM-th FIR sample, scales it (arithmetic shift + saturate to OUT_W) and queues it in a DEPTH-entry FIFO.
// Latency: 2 clocks from data_in to out_valid/out_data (stage register, then FIFO write) when the FIFO is empty.
// Backpressure: out_valid/out_ready handshake; a kept sample arriving at a full FIFO with no pop is dropped and sets ovf_flag.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-low reset
//   in_valid/data_in- filtered sample stream from the FIR (signed, N bits)
//   out_valid/out_data/out_ready - FIFO head handshake (signed, OUT_W bits)
//   level           - FIFO occupancy, 0..DEPTH
//   sat_flag/ovf_flag - sticky saturation / drop indicators, cleared by clr_flags
//
// Build option: define ROUND_EN to round half up before the shift instead of truncating.
module fir_decim_out #(
   parameter int N     = 16,
   parameter int OUT_W = 12,
   parameter int SHIFT = 2,
   parameter int DECIM = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [N-1:0]             data_in,
   output logic                     out_valid,
   output logic [OUT_W-1:0]         out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     sat_flag,
   output logic                     ovf_flag,
   input  logic                     clr_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   // Saturation bounds expressed at the N+1-bit working width.
   localparam logic signed [N:0] MAX_V = {{(N-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [N:0] MIN_V = {{(N-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   // ---------------------------------------------------------------
   // Decimation phase
   // ---------------------------------------------------------------
   logic [PW-1:0] phase;
   logic          keep;

   assign keep = in_valid && (phase == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (in_valid) begin
         if (phase == PW'(DECIM - 1))
            phase <= '0;
         else
            phase <= phase + PW'(1);
      end
   end

   // ---------------------------------------------------------------
   // Scaling: one guard bit above N keeps the rounding add from wrapping.
   // ---------------------------------------------------------------
   logic signed [N:0]       ext;
   logic signed [N:0]       pre;
   logic signed [N:0]       shifted;
   logic                    sat_hi;
   logic                    sat_lo;
   logic        [OUT_W-1:0] scaled;

   assign ext = {data_in[N-1], data_in};

`ifdef ROUND_EN
   // 2^(SHIFT-1), which collapses to zero when SHIFT is 0.
   localparam logic signed [N:0] RND = ({{N{1'b0}}, 1'b1} << SHIFT) >> 1;
   assign pre = ext + RND;
`else
   assign pre = ext;
`endif

   assign shifted = pre >>> SHIFT;
   assign sat_hi  = shifted > MAX_V;
   assign sat_lo  = shifted < MIN_V;

   always_comb begin
      scaled = shifted[OUT_W-1:0];
      if (sat_hi)
         scaled = MAX_V[OUT_W-1:0];
      else if (sat_lo)
         scaled = MIN_V[OUT_W-1:0];
   end

   // ---------------------------------------------------------------
   // Stage register
   // ---------------------------------------------------------------
   logic             s_valid;
   logic [OUT_W-1:0] s_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_valid <= 1'b0;
         s_data  <= '0;
      end else begin
         s_valid <= keep;
         if (keep)
            s_data <= scaled;
      end
   end

   // ---------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------
   logic [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             pop;
   logic             full;
   logic             wr_acc;
   logic             head_from_stage;
   logic [OUT_W-1:0] head_n;

   assign out_valid = (count != '0);
   assign level     = count;
   assign pop       = out_valid && out_ready;
   assign full      = (count == (AW+1)'(DEPTH));
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_acc    = s_valid && (!full || pop);

   // The written sample becomes the head when nothing else remains after the pop.
   assign head_from_stage = wr_acc && ((count == '0) || (pop && (count == (AW+1)'(1))));

   // out_data is registered so it holds the last head once the FIFO drains.
   always_comb begin
      head_n = out_data;
      if (head_from_stage)
         head_n = s_data;
      else if (pop && (count > (AW+1)'(1)))
         head_n = mem[rd_ptr + AW'(1)];
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         out_data <= '0;
      end else begin
         out_data <= head_n;
         if (wr_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sticky flags: a new event in the clearing cycle wins.
   // ---------------------------------------------------------------
   logic sat_set;
   logic ovf_set;

   assign sat_set = keep && (sat_hi || sat_lo);
   assign ovf_set = s_valid && !wr_acc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         sat_flag <= sat_set || (sat_flag && !clr_flags);
         ovf_flag <= ovf_set || (ovf_flag && !clr_flags);
      end
   end

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: directed stimulus for fir_decim_out with a queue-based reference model.
// Latency: model mirrors the 2-clock path as "stage slot" then "queue".
// Backpressure: model drops a stage sample when the queue holds DEPTH entries and no pop occurs.
module tb_fir_decim_out;

   localparam int N     = 16;
   localparam int OUT_W = 12;
   localparam int SHIFT = 2;
   localparam int DECIM = 4;
   localparam int DEPTH = 4;

   logic                   clk       = 1'b0;
   logic                   reset     = 1'b0;
   logic                   in_valid  = 1'b0;
   logic [N-1:0]           data_in   = '0;
   logic                   out_ready = 1'b0;
   logic                   clr_flags = 1'b0;
   logic                   out_valid;
   logic [OUT_W-1:0]       out_data;
   logic [$clog2(DEPTH):0] level;
   logic                   sat_flag;
   logic                   ovf_flag;

   fir_decim_out #(
      .N(N), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .level(level), .sat_flag(sat_flag), .ovf_flag(ovf_flag), .clr_flags(clr_flags)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          q[$];
   int          last_head = 0;
   bit          st_v      = 0;
   int          st_d      = 0;
   int          m_phase   = 0;
   bit          m_sat     = 0;
   bit          m_ovf     = 0;
   logic [OUT_W-1:0] got[$];

   // Floor division by 2^SHIFT, optional round-half-up, clamp to OUT_W.
   function automatic int scale(input int v, output bit clamped);
      int d, r, hi, lo;
      d  = 1 << SHIFT;
      hi = (1 << (OUT_W-1)) - 1;
      lo = -(1 << (OUT_W-1));
`ifdef ROUND_EN
      v = v + d / 2;
`endif
      if (v >= 0) r = v / d;
      else        r = -((-v + d - 1) / d);
      clamped = 0;
      if (r > hi) begin r = hi; clamped = 1; end
      if (r < lo) begin r = lo; clamped = 1; end
      return r;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         last_head = 0;
         st_v      = 0;
         st_d      = 0;
         m_phase   = 0;
         m_sat     = 0;
         m_ovf     = 0;
      end else begin
         bit m_pop, m_keep, m_cl, m_drop;
         int m_s;
         m_pop  = (q.size() > 0) && out_ready;
         m_drop = 0;
         if (m_pop) void'(q.pop_front());
         if (st_v) begin
            if (q.size() < DEPTH) q.push_back(st_d);
            else m_drop = 1;
         end
         if (q.size() > 0) last_head = q[0];
         m_keep = in_valid && (m_phase == 0);
         m_s    = scale(int'($signed(data_in)), m_cl);
         m_sat  = (m_keep && m_cl) ? 1'b1 : (clr_flags ? 1'b0 : m_sat);
         m_ovf  = m_drop ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
         st_v   = m_keep;
         st_d   = m_s;
         if (in_valid) m_phase = (m_phase + 1) % DECIM;
      end
   end

   // Single compare process, mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         chk("out_valid", int'(out_valid), int'(q.size() > 0));
         chk("level", int'(level), q.size());
         chk("out_data", int'($signed(out_data)), (q.size() > 0) ? q[0] : last_head);
         chk("sat_flag", int'(sat_flag), int'(m_sat));
         chk("ovf_flag", int'(ovf_flag), int'(m_ovf));
         if (out_valid && out_ready) got.push_back(out_data);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   // One kept sample followed by DECIM-1 discarded ones.
   task automatic kept(input logic [N-1:0] d);
      in_valid = 1'b1;
      data_in  = d;
      tick();
      data_in  = '0;
      repeat (DECIM-1) tick();
      in_valid = 1'b0;
   endtask

   task automatic chk_got(input string name, input int n,
                          input int e0, input int e1, input int e2, input int e3, input int e4);
      int e[5];
      e = '{e0, e1, e2, e3, e4};
      chk({name, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++)
         chk(name, int'($signed(got[i])), e[i]);
      got.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // 1. reset and idle
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_sat", int'(sat_flag), 0);
      chk("rst_ovf", int'(ovf_flag), 0);
      chk("rst_out_data", int'(out_data), 0);
      idle(10);

      // 2. decimation and latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      data_in   = 16'd4;
      tick();
      chk("lat1_valid", int'(out_valid), 0);
      data_in = 16'd8;
      tick();
      chk("lat2_valid", int'(out_valid), 1);
      chk("lat2_data", int'($signed(out_data)), 1);
      for (int d = 12; d <= 32; d += 4) begin
         data_in = N'(d);
         tick();
      end
      idle(4);
      chk_got("decim", 2, 1, 5, 0, 0, 0);

      // 3. saturation
      kept(16'h7FFF);
      kept(16'h8000);
      idle(4);
      chk_got("sat", 2, 2047, -2048, 0, 0, 0);
      chk("sat_set", int'(sat_flag), 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("sat_clr", int'(sat_flag), 0);

      // 4. backpressure and overflow
      out_ready = 1'b0;
      kept(16'd40);
      kept(16'd80);
      kept(16'd120);
      kept(16'd160);
      kept(16'd200);
      idle(2);
      chk("full_level", int'(level), 4);
      chk("full_ovf", int'(ovf_flag), 1);
      chk("full_head", int'($signed(out_data)), 10);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("ovf_clr", int'(ovf_flag), 0);
      // write and pop on the same edge while full
      in_valid = 1'b1;
      data_in  = 16'd240;
      tick();
      out_ready = 1'b1;
      data_in   = '0;
      tick();
      chk("wrpop_level", int'(level), 4);
      chk("wrpop_ovf", int'(ovf_flag), 0);
      chk("wrpop_head", int'($signed(out_data)), 20);
      tick();
      tick();
      idle(6);
      chk("drain_level", int'(level), 0);
      chk_got("drain", 5, 10, 20, 30, 40, 60);

      // 5. rounding
      kept(16'd6);
      kept(16'hFFFA);
      idle(4);
`ifdef ROUND_EN
      chk_got("round", 2, 2, -1, 0, 0, 0);
`else
      chk_got("round", 2, 1, -2, 0, 0, 0);
`endif

      // 6. reset mid-operation
      out_ready = 1'b0;
      kept(16'd4);
      kept(16'd8);
      kept(16'd12);
      chk("pre_rst_level", int'(level), 3);
      #1;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_level", int'(level), 0);
      repeat (2) tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      data_in   = 16'd100;
      tick();
      in_valid = 1'b0;
      data_in  = '0;
      tick();
      chk("post_rst_valid", int'(out_valid), 1);
      chk("post_rst_data", int'($signed(out_data)), 25);
      idle(3);
      chk_got("post_rst", 1, 25, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
